// File: rtl/jelly2_mul_add_pkg.sv
// Shared helpers for the multiply-add array family:
// rounding modes and the round/shift/saturate step.
package jelly2_mul_add_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    // Working width, wide enough that the rounding add cannot wrap
    localparam int RSS_W = 128;

    function automatic logic [RSS_W:0] round_shift_sat(
        input logic signed [RSS_W-1:0] x,
        input int                      shift,
        input int                      out_width,
        input int                      rounding
    );
        logic signed [RSS_W-1:0] one;
        logic signed [RSS_W-1:0] v;
        logic signed [RSS_W-1:0] hi;
        logic signed [RSS_W-1:0] lo;
        logic                    sat;
        one = RSS_W'(1);
        v   = x;
        if (rounding == ROUND_HALF_UP && shift > 0) begin
            v = v + (one <<< (shift - 1));
        end
        v   = v >>> shift;
        hi  = (one <<< (out_width - 1)) - one;
        lo  = -hi - one;
        sat = 1'b0;
        if (v > hi) begin
            v   = hi;
            sat = 1'b1;
        end else if (v < lo) begin
            v   = lo;
            sat = 1'b1;
        end
        return {sat, v};
    endfunction

endpackage

// File: rtl/jelly2_mul_add_array_output_fifo.sv
// First-word-fall-through FIFO with a registered head;
// capacity 2^PTR_WIDTH including the output register.
module jelly2_mul_add_array_output_fifo #(
    parameter int DATA_WIDTH = 19,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [PTR_WIDTH:0]    count
);

    localparam int CNT_W = PTR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [0:2**PTR_WIDTH-1];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  load_in;
    logic                  load_mem;
    logic                  write_mem;
    logic [CNT_W-1:0]      count_next;

    assign push = s_valid;
    assign pop  = m_valid & m_ready;

    // Head is refilled from the write port when nothing else is queued
    assign load_in   = push & ((count == '0) |
                               (pop & (count == CNT_W'(1))));
    assign load_mem  = pop & (count > CNT_W'(1));
    assign write_mem = push & ~load_in;

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (write_mem) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            count   <= count_next;
            m_valid <= (count_next != '0);
            if (write_mem) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load_mem) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (load_in) begin
                m_data <= s_data;
            end else if (load_mem) begin
                m_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: rtl/jelly2_mul_add_array_output.sv
// Output stage of the multiply-add array: round, shift,
// saturate, buffer, and stall the array through out_cke.
module jelly2_mul_add_array_output
    import jelly2_mul_add_pkg::*;
#(
    parameter int MAC_WIDTH = 48,
    parameter int SHIFT     = 16,
    parameter int ROUNDING  = 1,
    parameter int OUT_WIDTH = 18,
    parameter int PTR_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic                        out_cke,
    input  logic signed [MAC_WIDTH-1:0] s_data,
    input  logic                        s_valid,
    output logic signed [OUT_WIDTH-1:0] m_data,
    output logic                        m_sat,
    output logic                        m_valid,
    input  logic                        m_ready
);

    localparam int CNT_W = PTR_WIDTH + 1;
    localparam int DW    = OUT_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH =
        CNT_W'(2**PTR_WIDTH);

    logic signed [RSS_W-1:0] acc_ext;
    logic [RSS_W:0]          res;
    logic                    push;
    logic                    pop;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_next;
    logic [DW-1:0]           fifo_out;
    logic                    unused_res;

    assign acc_ext = {{(RSS_W-MAC_WIDTH){s_data[MAC_WIDTH-1]}},
                      s_data};
    assign res     = round_shift_sat(acc_ext, SHIFT,
                                     OUT_WIDTH, ROUNDING);
    assign unused_res = &{1'b0, res[RSS_W-1:OUT_WIDTH]};

    assign push = out_cke & s_valid;
    assign pop  = m_valid & m_ready;

    jelly2_mul_add_array_output_fifo #(
        .DATA_WIDTH (DW),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .s_data  ({res[RSS_W], res[OUT_WIDTH-1:0]}),
        .s_valid (push),
        .m_data  (fifo_out),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .count   (count)
    );

    assign {m_sat, m_data} = fifo_out;

    // Only a cke edge can push, so this keeps occupancy <= DEPTH
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_cke <= 1'b0;
        end else begin
            out_cke <= (count_next < DEPTH);
        end
    end

endmodule
